// File: rtl/apu_cmd_sequencer.sv
// apu_cmd_sequencer: turns the host's nibble-encoded byte stream into 8-bit
// APU register writes, queues them in a small first-word-fall-through FIFO
// and issues them to the register bus under a valid/ready handshake.
module apu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic [1:0] bank,
    output logic       overflow,
    output logic       proto_err,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] LOW_HELD = 1'b1;

    logic [0:0]    state;
    logic [1:0]    stage_reg;
    logic [3:0]    stage_nib;
    logic [TW-1:0] idle_cnt;

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Byte classification
    logic       is_bank;
    logic       is_nib;
    logic [1:0] nib_reg;
    logic       nib_hi;
    logic [3:0] nib_val;
    logic       push_req;
    logic       hi_err;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;

    assign is_bank  = rx_valid &  rx_data[7];
    assign is_nib   = rx_valid & ~rx_data[7];
    assign nib_reg  = rx_data[6:5];
    assign nib_hi   = rx_data[4];
    assign nib_val  = rx_data[3:0];

    // A high nibble completes a write only if it matches the staged register
    assign push_req = is_nib & nib_hi & (state == LOW_HELD) & (nib_reg == stage_reg);
    assign hi_err   = is_nib & nib_hi & ((state == IDLE) | (nib_reg != stage_reg));

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = ~empty & wr_ready;
    // When full, a simultaneous pop frees the slot the push needs
    assign push  = push_req & (~full | pop);
    assign drop  = push_req & full & ~pop;

    // Decoder FSM: stage low nibbles, pair them with high nibbles, time out stale stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage_reg <= '0;
            stage_nib <= '0;
            idle_cnt  <= '0;
        end else if (is_bank) begin
            state    <= IDLE;
            idle_cnt <= '0;
        end else if (is_nib) begin
            idle_cnt <= '0;
            if (!nib_hi) begin
                state     <= LOW_HELD;
                stage_reg <= nib_reg;
                stage_nib <= nib_val;
            end else begin
                state <= IDLE;
            end
        end else if (state == LOW_HELD) begin
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
                state    <= IDLE;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

    // Bank register and sticky error flags; 0xFC-0xFF also clear the flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank      <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else if (is_bank) begin
            bank <= rx_data[1:0];
            if (rx_data[6:2] == 5'b11111) begin
                overflow  <= 1'b0;
                proto_err <= 1'b0;
            end
        end else begin
            if (hi_err) proto_err <= 1'b1;
            if (drop)   overflow  <= 1'b1;
        end
    end

    // FIFO storage: one register per entry, bank sampled at the high nibble
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem[gi] <= '0;
                end else if (push && (wr_ptr == AW'(gi))) begin
                    mem[gi] <= {bank, stage_reg, nib_val, stage_nib};
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign wr_valid = ~empty;
    assign wr_addr  = mem[rd_ptr][11:8];
    assign wr_data  = mem[rd_ptr][7:0];
    assign busy     = ~empty | (state == LOW_HELD);

endmodule

// File: tb/tb_apu_cmd_sequencer.sv
// Directed testbench for apu_cmd_sequencer: drives host bytes, logs every
// accepted register write and compares against hand-computed expectations.
module tb_apu_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [1:0] bank;
    logic       overflow;
    logic       proto_err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];

    apu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .bank      (bank),
        .overflow  (overflow),
        .proto_err (proto_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log each completed handshake; inputs only change 2ns after posedge
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            got_q.push_back({wr_addr, wr_data});
            $display("write addr=0x%0h data=0x%02h", wr_addr, wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        wr_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_bank", bank, 0);
        check("rst_overflow", overflow, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Basic decode, one write per register
        send_byte(8'h80);
        send_byte(8'h27);
        check("busy_staged", busy, 1);
        send_byte(8'h3A);
        repeat (4) tick();
        exp_q.push_back(12'h1A7);
        check_writes("first_write");
        check("bank0", bank, 0);

        send_byte(8'h02); send_byte(8'h18);
        send_byte(8'h4C); send_byte(8'h57);
        send_byte(8'h69); send_byte(8'h70);
        repeat (4) tick();
        exp_q.push_back(12'h082);
        exp_q.push_back(12'h27C);
        exp_q.push_back(12'h309);
        check_writes("order");
        check("idle_after_order", busy, 0);

        // Bank select, stage dropped by bank command, flag clear
        send_byte(8'h81); send_byte(8'h4C); send_byte(8'h57);
        repeat (4) tick();
        exp_q.push_back(12'h67C);
        check_writes("bank1_write");
        check("bank1", bank, 1);
        send_byte(8'h2B); send_byte(8'h80); send_byte(8'h3C);
        repeat (4) tick();
        check_writes("bank_drop");
        check("proto_err_set", proto_err, 1);
        check("bank_back0", bank, 0);
        send_byte(8'hFC);
        check("proto_err_clr", proto_err, 0);
        check("bank_fc", bank, 0);

        // Overflow: DEPTH+1 pairs while stalled
        wr_ready = 1'b0;
        for (int n = 0; n <= DEPTH; n++) begin
            send_byte(8'(n));
            send_byte(8'(8'h10 + n));
        end
        tick();
        check("ovf_set", overflow, 1);
        check("stall_valid", wr_valid, 1);
        check("stall_data", wr_data, 8'h00);
        tick();
        check("stall_hold_data", wr_data, 8'h00);
        wr_ready = 1'b1;
        repeat (8) tick();
        for (int n = 0; n < DEPTH; n++) exp_q.push_back(12'(n * 8'h11));
        check_writes("ovf_drain");
        check("ovf_empty", wr_valid, 0);

        // Full FIFO, push and pop in the same cycle
        send_byte(8'hFC);
        check("ovf_clr", overflow, 0);
        wr_ready = 1'b0;
        for (int n = 1; n <= DEPTH; n++) begin
            send_byte(8'(n));
            send_byte(8'(8'h10 + n));
        end
        send_byte(8'h05);
        rx_data  = 8'h15;
        rx_valid = 1'b1;
        wr_ready = 1'b1;
        tick();
        rx_valid = 1'b0;
        wr_ready = 1'b0;
        tick();
        check("pushpop_no_ovf", overflow, 0);
        check("pushpop_valid", wr_valid, 1);
        wr_ready = 1'b1;
        repeat (8) tick();
        for (int n = 1; n <= DEPTH + 1; n++) exp_q.push_back(12'(n * 8'h11));
        check_writes("pushpop");
        check("pushpop_empty", wr_valid, 0);

        // Timeout expired: high nibble is an error
        send_byte(8'h27);
        repeat (TIMEOUT) tick();
        check("timeout_idle", busy, 0);
        send_byte(8'h3A);
        repeat (4) tick();
        check_writes("timeout_drop");
        check("timeout_err", proto_err, 1);

        // Just inside the timeout: write goes through
        send_byte(8'hFC);
        send_byte(8'h27);
        repeat (TIMEOUT - 2) tick();
        check("pre_timeout_busy", busy, 1);
        send_byte(8'h3A);
        repeat (4) tick();
        exp_q.push_back(12'h1A7);
        check_writes("timeout_ok");
        check("timeout_ok_err", proto_err, 0);

        // Mid-stream reset drops queued writes
        wr_ready = 1'b0;
        send_byte(8'h82);
        send_byte(8'h01); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h32);
        send_byte(8'h43); send_byte(8'h53);
        send_byte(8'h04);
        tick();
        check("pre_rst_valid", wr_valid, 1);
        check("pre_rst_bank", bank, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", wr_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bank", bank, 0);
        tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (10) tick();
        check_writes("post_rst");
        check("post_rst_valid", wr_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
